// File: rtl/pipe_stage_buf_pkg.sv
// Shared definitions for the inter-stage pipeline buffer: default sizing
// and the handshake state encoding used by both the write and read FSMs.
package pipe_stage_buf_pkg;

  localparam int PSB_DATA_W = 128;
  localparam int PSB_DEPTH  = 2;

  typedef enum logic [1:0] {
    HS_IDLE = 2'd0,
    HS_ACK  = 2'd1,
    HS_HOLD = 2'd2
  } hsState_t;

endpackage

// File: rtl/pipe_stage_buf_ram.sv
// Payload storage for the stage buffer: DEPTH words, one synchronous write
// port and one asynchronous read port. Contents are never reset; the
// occupancy count in the parent decides which words are meaningful.
module pipe_stage_buf_ram #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 2,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [PTR_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [PTR_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Capture the upstream payload into the addressed slot on an accepted write.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline buffer. Upstream writes are answered with a one-cycle
// buf_wack, downstream reads with a one-cycle buf_rack carrying dout. Each
// side runs its own IDLE/ACK/HOLD handshake so a level request held high is
// served exactly once. A taken-jump flush empties the buffer in one edge.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int DATA_W = PSB_DATA_W,
  parameter int DEPTH  = PSB_DEPTH,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              buf_we,
  input  logic [DATA_W-1:0] din,
  output logic              buf_wack,
  output logic              buf_avail,
  input  logic              buf_re,
  output logic [DATA_W-1:0] dout,
  output logic              buf_rack,
  input  logic              flush,
  output logic [PTR_W:0]    count
);

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;

  hsState_t          r_wState;
  hsState_t          w_wStateNext;
  hsState_t          r_rState;
  hsState_t          w_rStateNext;
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [PTR_W:0]    r_count;
  logic              r_wack;
  logic              r_rack;
  logic [DATA_W-1:0] r_dout;
  logic [DATA_W-1:0] w_ramRdata;
  logic              w_push;
  logic              w_pop;
  logic              w_ramWe;

  // Decide this edge's pop and push; a pop frees the slot a full-buffer push
  // needs, and a write arriving with flush is acknowledged but not stored.
  always_comb begin
    w_pop   = (r_rState == HS_IDLE) && buf_re && (r_count != '0) && !flush;
    w_push  = (r_wState == HS_IDLE) && buf_we &&
              ((r_count < CNT_FULL) || w_pop || flush);
    w_ramWe = w_push && !flush;
  end

  // Write handshake: accept once, pulse the ack, then wait for buf_we to drop.
  always_comb begin
    w_wStateNext = r_wState;
    unique case (r_wState)
      HS_IDLE: if (w_push) w_wStateNext = HS_ACK;
      HS_ACK:  w_wStateNext = buf_we ? HS_HOLD : HS_IDLE;
      HS_HOLD: if (!buf_we) w_wStateNext = HS_IDLE;
      default: w_wStateNext = HS_IDLE;
    endcase
  end

  // Read handshake mirrors the write side; an unserved request stays in IDLE.
  always_comb begin
    w_rStateNext = r_rState;
    unique case (r_rState)
      HS_IDLE: if (w_pop) w_rStateNext = HS_ACK;
      HS_ACK:  w_rStateNext = buf_re ? HS_HOLD : HS_IDLE;
      HS_HOLD: if (!buf_re) w_rStateNext = HS_IDLE;
      default: w_rStateNext = HS_IDLE;
    endcase
  end

  // Handshake state registers for both sides.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wState <= HS_IDLE;
      r_rState <= HS_IDLE;
    end else begin
      r_wState <= w_wStateNext;
      r_rState <= w_rStateNext;
    end
  end

  // Pointers and occupancy; flush wins over any push or pop on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTR_ONE;
      if (w_pop)  r_rdPtr <= r_rdPtr + PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (w_pop && !w_push) r_count <= r_count - CNT_ONE;
    end
  end

  // Ack pulses and the read data register, which holds until the next pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wack <= 1'b0;
      r_rack <= 1'b0;
      r_dout <= '0;
    end else begin
      r_wack <= w_push;
      r_rack <= w_pop;
      if (w_pop) r_dout <= w_ramRdata;
    end
  end

  pipe_stage_buf_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ramWe),
    .i_waddr (r_wrPtr),
    .i_wdata (din),
    .i_raddr (r_rdPtr),
    .o_rdata (w_ramRdata)
  );

  assign buf_wack  = r_wack;
  assign buf_rack  = r_rack;
  assign dout      = r_dout;
  assign count     = r_count;
  assign buf_avail = (r_count != '0) && !flush;

endmodule
